// File: rtl/pipe_skid_stage.sv
// Pipeline stage with a main register and a one-entry skid buffer so that
// in_ready is registered and never depends combinationally on out_ready.
//
// state    | meaning
// ST_EMPTY | no valid entry; out_ctrl carries the bubble encoding
// ST_FULL  | main register holds a valid entry, skid register unused
// ST_SKID  | main and skid both hold valid entries; upstream is held off
module pipe_skid_stage #(
  parameter int                 DATA_W      = 192,
  parameter int                 CTRL_W      = 16,
  parameter logic [CTRL_W-1:0]  BUBBLE_CTRL = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [15:0]       stall_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_e;

  state_e              state_q,     state_d;
  logic                in_ready_q,  in_ready_d;
  logic                out_valid_q, out_valid_d;
  logic [CTRL_W-1:0]   main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0]   main_data_q, main_data_d;
  logic [CTRL_W-1:0]   skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0]   skid_data_q, skid_data_d;
  logic [15:0]         stall_cnt_q, stall_cnt_d;

  logic                in_xfer;
  logic                out_xfer;

  assign in_xfer  = in_valid & in_ready_q;
  assign out_xfer = out_valid_q & out_ready;

  always_comb begin
    state_d     = state_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;
    stall_cnt_d = stall_cnt_q;

    unique case (state_q)
      ST_EMPTY: begin
        if (in_xfer) begin
          main_ctrl_d = in_ctrl;
          main_data_d = in_data;
          state_d     = ST_FULL;
        end
      end
      ST_FULL: begin
        if (in_xfer && out_xfer) begin
          main_ctrl_d = in_ctrl;
          main_data_d = in_data;
        end else if (in_xfer) begin
          skid_ctrl_d = in_ctrl;
          skid_data_d = in_data;
          state_d     = ST_SKID;
        end else if (out_xfer) begin
          state_d     = ST_EMPTY;
        end
      end
      ST_SKID: begin
        // in_ready is low here, so only the drain of main can happen
        if (out_xfer) begin
          main_ctrl_d = skid_ctrl_q;
          main_data_d = skid_data_q;
          state_d     = ST_FULL;
        end
      end
      default: state_d = ST_EMPTY;
    endcase

    // An idle stage must present a bubble; the data word is left as-is.
    if (state_d == ST_EMPTY) begin
      main_ctrl_d = BUBBLE_CTRL;
    end

    if (flush) begin
      state_d     = ST_EMPTY;
      main_ctrl_d = BUBBLE_CTRL;
      main_data_d = '0;
      skid_ctrl_d = BUBBLE_CTRL;
      skid_data_d = '0;
    end

    if (out_valid_q && !out_ready && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end

    in_ready_d  = (state_d != ST_SKID);
    out_valid_d = (state_d != ST_EMPTY);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      main_ctrl_q <= BUBBLE_CTRL;
      main_data_q <= '0;
      skid_ctrl_q <= BUBBLE_CTRL;
      skid_data_q <= '0;
      stall_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_ctrl  = main_ctrl_q;
  assign out_data  = main_data_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Directed bench for pipe_skid_stage: each task drives one scenario and
// compares outputs against hand-derived values one step after the clock edge.
module tb_pipe_skid_stage;

  localparam int DATA_W = 192;
  localparam int CTRL_W = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  logic [15:0]       stall_cnt;

  int passed = 0;
  int total  = 0;

  pipe_skid_stage dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_data  (out_data),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] mk_data(input int n);
    logic [31:0] w;
    w = 32'hA5A50000 | 32'(n);
    return {6{w}};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input int n);
    in_valid = v;
    in_ctrl  = CTRL_W'(n);
    in_data  = mk_data(n);
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    flush     = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 0);
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid);
    else passed++;
    total++;
    if (out_ctrl !== 16'h0000) $display("FAIL reset_out_ctrl: got %h expected 0000", out_ctrl);
    else passed++;
    total++;
    if (out_data !== '0) $display("FAIL reset_out_data: got %h expected 0", out_data);
    else passed++;
    total++;
    if (stall_cnt !== 16'd0) $display("FAIL reset_stall_cnt: got %0d expected 0", stall_cnt);
    else passed++;
    step();
    total++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    else passed++;
  endtask

  task automatic test_single();
    do_reset();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_ctrl   = 16'h0011;
    in_data   = mk_data(32'hAA);
    step();
    drive(1'b0, 0);
    total++;
    if (out_valid !== 1'b1 || out_ctrl !== 16'h0011 || out_data !== mk_data(32'hAA))
      $display("FAIL single_out: got v=%b c=%h expected v=1 c=0011", out_valid, out_ctrl);
    else passed++;
    step();
    total++;
    if (out_valid !== 1'b0 || out_ctrl !== 16'h0000)
      $display("FAIL single_bubble: got v=%b c=%h expected v=0 c=0000", out_valid, out_ctrl);
    else passed++;
    total++;
    if (out_data !== mk_data(32'hAA)) $display("FAIL single_data_hold: got %h expected held payload", out_data);
    else passed++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    out_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      drive(1'b1, k);
      total++;
      if (in_ready !== 1'b1) $display("FAIL b2b_in_ready_%0d: got %b expected 1", k, in_ready);
      else passed++;
      step();
      total++;
      if (out_valid !== 1'b1 || out_ctrl !== CTRL_W'(k) || out_data !== mk_data(k))
        $display("FAIL b2b_out_%0d: got v=%b c=%h expected v=1 c=%h", k, out_valid, out_ctrl, CTRL_W'(k));
      else passed++;
    end
    drive(1'b0, 0);
    step();
    total++;
    if (out_valid !== 1'b0) $display("FAIL b2b_drain: got %b expected 0", out_valid);
    else passed++;
    total++;
    if (stall_cnt !== 16'd0) $display("FAIL b2b_stall_cnt: got %0d expected 0", stall_cnt);
    else passed++;
  endtask

  task automatic test_skid();
    do_reset();
    out_ready = 1'b0;
    drive(1'b1, 5);
    step();
    drive(1'b1, 6);
    total++;
    if (in_ready !== 1'b1) $display("FAIL skid_ready_full: got %b expected 1", in_ready);
    else passed++;
    step();
    drive(1'b1, 7);
    total++;
    if (in_ready !== 1'b0 || out_ctrl !== 16'd5)
      $display("FAIL skid_enter: got r=%b c=%h expected r=0 c=0005", in_ready, out_ctrl);
    else passed++;
    step();
    step();
    total++;
    if (in_ready !== 1'b0 || out_ctrl !== 16'd5 || stall_cnt !== 16'd3)
      $display("FAIL skid_hold: got r=%b c=%h s=%0d expected r=0 c=0005 s=3", in_ready, out_ctrl, stall_cnt);
    else passed++;
    out_ready = 1'b1;
    step();
    total++;
    if (out_valid !== 1'b1 || out_ctrl !== 16'd6 || out_data !== mk_data(6) || in_ready !== 1'b1)
      $display("FAIL skid_out6: got v=%b c=%h r=%b expected v=1 c=0006 r=1", out_valid, out_ctrl, in_ready);
    else passed++;
    step();
    drive(1'b0, 0);
    total++;
    if (out_valid !== 1'b1 || out_ctrl !== 16'd7 || out_data !== mk_data(7))
      $display("FAIL skid_out7: got v=%b c=%h expected v=1 c=0007", out_valid, out_ctrl);
    else passed++;
    step();
    total++;
    if (out_valid !== 1'b0 || stall_cnt !== 16'd3)
      $display("FAIL skid_drain: got v=%b s=%0d expected v=0 s=3", out_valid, stall_cnt);
    else passed++;
  endtask

  task automatic test_flush();
    do_reset();
    out_ready = 1'b0;
    drive(1'b1, 5);
    step();
    drive(1'b1, 6);
    step();
    flush = 1'b1;
    drive(1'b1, 9);
    step();
    flush = 1'b0;
    drive(1'b0, 0);
    total++;
    if (out_valid !== 1'b0 || out_ctrl !== 16'h0000 || out_data !== '0 || in_ready !== 1'b1)
      $display("FAIL flush_state: got v=%b c=%h r=%b expected v=0 c=0000 d=0 r=1", out_valid, out_ctrl, in_ready);
    else passed++;
    total++;
    if (stall_cnt !== 16'd2) $display("FAIL flush_stall_cnt: got %0d expected 2", stall_cnt);
    else passed++;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      total++;
      if (out_valid !== 1'b0) $display("FAIL flush_no_stale_%0d: got v=%b c=%h expected v=0", k, out_valid, out_ctrl);
      else passed++;
    end
  endtask

  task automatic test_stall_sat();
    do_reset();
    out_ready = 1'b0;
    drive(1'b1, 3);
    step();
    drive(1'b0, 0);
    for (int k = 0; k < 65534; k++) step();
    total++;
    if (stall_cnt !== 16'hFFFE) $display("FAIL sat_below: got %h expected FFFE", stall_cnt);
    else passed++;
    step();
    total++;
    if (stall_cnt !== 16'hFFFF) $display("FAIL sat_reach: got %h expected FFFF", stall_cnt);
    else passed++;
    for (int k = 0; k < 4466; k++) step();
    total++;
    if (stall_cnt !== 16'hFFFF || out_valid !== 1'b1)
      $display("FAIL sat_hold: got s=%h v=%b expected s=FFFF v=1", stall_cnt, out_valid);
    else passed++;
    flush = 1'b1;
    step();
    flush = 1'b0;
    total++;
    if (stall_cnt !== 16'hFFFF || out_valid !== 1'b0)
      $display("FAIL sat_flush: got s=%h v=%b expected s=FFFF v=0", stall_cnt, out_valid);
    else passed++;
    reset = 1'b1;
    step();
    reset = 1'b0;
    total++;
    if (stall_cnt !== 16'd0) $display("FAIL sat_reset: got %h expected 0000", stall_cnt);
    else passed++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_ready = 1'b0;
    drive(1'b1, 3);
    step();
    reset = 1'b1;
    drive(1'b1, 4);
    step();
    reset = 1'b0;
    drive(1'b0, 0);
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_ctrl !== 16'h0000 || stall_cnt !== 16'd0)
      $display("FAIL rstmid_state: got v=%b r=%b c=%h s=%0d expected v=0 r=1 c=0000 s=0",
               out_valid, in_ready, out_ctrl, stall_cnt);
    else passed++;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      total++;
      if (out_valid !== 1'b0) $display("FAIL rstmid_no_stale_%0d: got v=%b c=%h expected v=0", k, out_valid, out_ctrl);
      else passed++;
    end
  endtask

  initial begin
    reset     = 1'b1;
    flush     = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 0);
    test_reset();
    test_single();
    test_back_to_back();
    test_skid();
    test_flush();
    test_stall_sat();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
